uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_arb.sv | 35 +++
 rtl/uart_tx.sv | 56 +++++
 rtl/uart_tx_sched.sv | 144 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_pkg;

    localparam int BAUD_MAX_9600   = 5207;
    localparam int BAUD_MAX_TEST   = 50;
    localparam int FRAME_DATA_BITS = 9;   // start bit + 8 data bits
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

    // Full frame length in sclk cycles, including idle-high guard bits.
    function automatic int frame_cycles(input int baud_max, input int guard_bits);
        return (FRAME_DATA_BITS + guard_bits) * (baud_max + 1);
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module uart_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            valid
);

    int             idx;
    logic [IDW-1:0] idx_l;

    // Walk from the farthest offset back to ptr so the closest requester overrides.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        idx_l     = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx   = (int'(ptr) + off) % NREQ;
            idx_l = idx[IDW-1:0];
            if (req[idx_l]) begin
                grant        = '0;
                grant[idx_l] = 1'b1;
                grant_idx    = idx_l;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Minimal 8N transmitter: start bit then 8 data bits LSB-first, line idles high.
// It has no busy output; a trigger during a frame restarts it.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_MAX = BAUD_MAX_9600
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       tx_trig,
    input  logic [7:0] tx_data,
    output logic       tx
);

    localparam logic [CNT_W-1:0] BAUD_LD = CNT_W'(BAUD_MAX);

    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bits_q, bits_d;
    logic [CNT_W-1:0] baud_q, baud_d;

    // Load the frame on trigger, then shift one bit per bit period.
    always_comb begin
        shift_d = shift_q;
        bits_d  = bits_q;
        baud_d  = baud_q;
        if (tx_trig) begin
            shift_d = {tx_data, 1'b0};
            bits_d  = 4'(FRAME_DATA_BITS);
            baud_d  = BAUD_LD;
        end else if (bits_q != 4'd0) begin
            if (baud_q == '0) begin
                shift_d = {1'b1, shift_q[8:1]};
                bits_d  = bits_q - 4'd1;
                baud_d  = BAUD_LD;
            end else begin
                baud_d = baud_q - CNT_W'(1);
            end
        end
    end

    // Shift register, bit counter and bit-period down-counter.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 9'h1FF;
            bits_q  <= 4'd0;
            baud_q  <= '0;
        end else begin
            shift_q <= shift_d;
            bits_q  <= bits_d;
            baud_q  <= baud_d;
        end
    end

    assign tx = (bits_q != 4'd0) ? shift_q[0] : 1'b1;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte requesters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | line free; grant a winner when en=1 and any req is set
//   ST_LOAD | one cycle: tx_trig + ack to winner, load frame down-counter
//   ST_WAIT | frame in flight; count down to zero, then back to ST_IDLE
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int BAUD_MAX   = BAUD_MAX_9600,
    parameter int GUARD_BITS = 1,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              tx_trig,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    localparam int               FRAME_CYCLES = frame_cycles(BAUD_MAX, GUARD_BITS);
    localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'(FRAME_CYCLES - 1);

    sched_state_t     state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_trig_q, tx_trig_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;

    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_idx;
    logic             arb_valid;
    logic [7:0]       win_byte;
    logic [IDW-1:0]   ptr_next;

    uart_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // Byte of the winning requester, selected by the one-hot grant.
    always_comb begin
        win_byte = '0;
        for (int k = 0; k < NREQ; k++) begin
            win_byte = win_byte | (data[8*k +: 8] & {8{arb_grant[k]}});
        end
    end

    // Priority starts just after the winner, wrapping at NREQ.
    always_comb begin
        ptr_next = arb_idx + IDW'(1);
        if (arb_idx == IDW'(NREQ - 1)) begin
            ptr_next = '0;
        end
    end

    // Next-state and registered-output logic; en only gates the grant in IDLE.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_trig_d  = 1'b0;
        ack_d      = '0;
        busy_d     = busy_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (en && arb_valid) begin
                    state_d    = ST_LOAD;
                    tx_trig_d  = 1'b1;
                    ack_d      = arb_grant;
                    busy_d     = 1'b1;
                    tx_data_d  = win_byte;
                    grant_id_d = arb_idx;
                    ptr_d      = ptr_next;
                end
            end
            ST_LOAD: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_trig_q  <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_trig_q  <= tx_trig_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign tx_trig  = tx_trig_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched driving a uart_tx, against a timeline reference model.
module tb_uart_tx_sched;

    localparam int NREQ  = 4;
    localparam int BAUD  = 50;
    localparam int GUARD = 1;
    localparam int BITP  = BAUD + 1;
    localparam int FRAME = (9 + GUARD) * BITP;   // WAIT length, 510

    logic              sclk  = 1'b0;
    logic              rst_n = 1'b0;
    logic              en    = 1'b0;
    logic [NREQ-1:0]   req   = '0;
    logic [NREQ*8-1:0] data  = '0;
    logic [NREQ-1:0]   ack;
    logic              tx_trig;
    logic [7:0]        tx_data;
    logic              busy;
    logic [1:0]        grant_id;
    logic              tx;

    always #5 sclk = ~sclk;

    uart_tx_sched #(
        .NREQ       (NREQ),
        .BAUD_MAX   (BAUD),
        .GUARD_BITS (GUARD)
    ) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .tx_trig  (tx_trig),
        .tx_data  (tx_data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    uart_tx #(
        .BAUD_MAX (BAUD)
    ) u_tx (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .tx_trig (tx_trig),
        .tx_data (tx_data),
        .tx      (tx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a grant decided in an idle cycle c yields trig at c+1,
    // busy for FRAME+1 cycles and the next grant no earlier than c+FRAME+2.
    int         cyc        = 0;
    int         idle_from  = 0;
    int         trig_at    = 0;
    bit         have_frame = 1'b0;
    int         m_last     = NREQ - 1;
    int         m_gid      = 0;
    logic [7:0] m_byte     = 8'h00;
    logic       prev_busy  = 1'b0;

    int trig_log[$];
    int ack_log[$];
    int busy_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ack_id(input logic [NREQ-1:0] a);
        int id;
        id = -1;
        for (int k = 0; k < NREQ; k++) if (a[k]) id = k;
        return id;
    endfunction

    task automatic model_reset();
        have_frame = 1'b0;
        m_last     = NREQ - 1;
        m_gid      = 0;
        m_byte     = 8'h00;
        idle_from  = 0;
    endtask

    // One clock: model decides on current inputs, then every output is compared.
    task automatic step();
        int         w;
        int         kk;
        int         bi;
        logic       e_trig;
        logic [3:0] e_ack;
        logic       e_busy;
        logic       e_tx;
        if (rst_n && en && (req != '0) && cyc >= idle_from) begin
            w = -1;
            for (int i = 1; i <= NREQ; i++) begin
                kk = (m_last + i) % NREQ;
                if (w < 0 && req[kk]) w = kk;
            end
            m_last     = w;
            m_gid      = w;
            m_byte     = 8'(data >> (8 * w));
            trig_at    = cyc + 1;
            idle_from  = cyc + FRAME + 2;
            have_frame = 1'b1;
        end
        prev_busy = busy;
        @(posedge sclk);
        #1;
        cyc++;
        e_trig = have_frame && (cyc == trig_at);
        e_ack  = e_trig ? 4'(1 << m_last) : 4'b0000;
        e_busy = have_frame && (cyc >= trig_at) && (cyc <= trig_at + FRAME);
        e_tx   = 1'b1;
        if (have_frame && cyc > trig_at && cyc <= trig_at + 9 * BITP) begin
            bi   = (cyc - trig_at - 1) / BITP;
            e_tx = (bi == 0) ? 1'b0 : m_byte[bi-1];
        end
        check_eq("tx_trig", tx_trig, e_trig);
        check_eq("ack", ack, e_ack);
        check_eq("busy", busy, e_busy);
        check_eq("tx_data", tx_data, have_frame ? m_byte : 8'h00);
        check_eq("grant_id", grant_id, have_frame ? m_gid : 0);
        check_eq("tx_line", tx, e_tx);
        check_eq("trig_while_busy", tx_trig && prev_busy, 1'b0);
        check_eq("ack_onehot0", $onehot0(ack), 1'b1);
        check_eq("ack_with_trig", ack != '0, tx_trig);
        if (tx_trig) begin
            trig_log.push_back(cyc);
            ack_log.push_back(ack_id(ack));
        end
        if (busy) busy_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_trigs(input string tag, input int n, input int limit);
        int i;
        i = 0;
        while (trig_log.size() < n && i < limit) begin
            step();
            i++;
        end
        check_eq(tag, trig_log.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // Reset state
        repeat (3) @(posedge sclk);
        #1;
        check_eq("rst_trig", tx_trig, 1'b0);
        check_eq("rst_ack", ack, 4'b0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_grant_id", grant_id, 2'd0);
        check_eq("rst_tx", tx, 1'b1);
        rst_n = 1'b1;
        run(3);

        // Single request from requester 1 with 0xA5
        en         = 1'b1;
        data[15:8] = 8'hA5;
        req        = 4'b0010;
        busy_cnt   = 0;
        step();
        check_eq("single_ack", ack, 4'b0010);
        check_eq("single_trig", tx_trig, 1'b1);
        check_eq("single_data", tx_data, 8'hA5);
        req = '0;
        run(FRAME + 20);
        check_eq("single_busy_len", busy_cnt, FRAME + 1);

        // Contention from a fresh pointer: 0,1,2,3,0, 512 cycles apart
        do_reset();
        for (int k = 0; k < NREQ; k++) data[8*k +: 8] = 8'($urandom);
        trig_log.delete();
        ack_log.delete();
        req = 4'b1111;
        wait_trigs("cont_count", 5, 6 * (FRAME + 2));
        req = '0;
        if (ack_log.size() == 5) begin
            check_eq("cont_order0", ack_log[0], 0);
            check_eq("cont_order1", ack_log[1], 1);
            check_eq("cont_order2", ack_log[2], 2);
            check_eq("cont_order3", ack_log[3], 3);
            check_eq("cont_order4", ack_log[4], 0);
            for (int i = 0; i < 4; i++)
                check_eq("cont_spacing", trig_log[i+1] - trig_log[i], FRAME + 2);
        end
        run(FRAME + 5);

        // Pointer wrap: grant 3, then 4'b1001 gives 0 then 3
        trig_log.delete();
        ack_log.delete();
        req = 4'b1000;
        wait_trigs("wrap_first", 1, 10);
        req = 4'b1001;
        trig_log.delete();
        ack_log.delete();
        wait_trigs("wrap_count", 2, 3 * (FRAME + 2));
        req = '0;
        if (ack_log.size() == 2) begin
            check_eq("wrap_id0", ack_log[0], 0);
            check_eq("wrap_id1", ack_log[1], 3);
        end
        run(FRAME + 5);

        // Enable gating and en dropped mid-frame
        trig_log.delete();
        en  = 1'b0;
        req = 4'b0100;
        run(20);
        check_eq("en_blocked", trig_log.size(), 0);
        en = 1'b1;
        step();
        check_eq("en_trig", tx_trig, 1'b1);
        check_eq("en_ack", ack, 4'b0100);
        req = 4'b0001;
        run(100);
        en = 1'b0;
        run(2 * FRAME);
        check_eq("en_drop_trigs", trig_log.size(), 1);
        check_eq("en_drop_idle", busy, 1'b0);
        req = '0;
        en  = 1'b1;
        run(5);

        // Reset at WAIT cycle 200
        req = 4'b0001;
        data[7:0] = 8'h3C;
        step();
        check_eq("mr_trig", tx_trig, 1'b1);
        req = '0;
        t0  = cyc;
        run(200);
        check_eq("mr_at_wait200", cyc - t0, 200);
        check_eq("mr_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_trig0", tx_trig, 1'b0);
        check_eq("mr_ack0", ack, 4'b0000);
        check_eq("mr_busy0", busy, 1'b0);
        check_eq("mr_tx_data0", tx_data, 8'h00);
        check_eq("mr_grant_id0", grant_id, 2'd0);
        check_eq("mr_tx_high", tx, 1'b1);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        trig_log.delete();
        run(3);
        check_eq("mr_no_trig", trig_log.size(), 0);
        data[7:0] = 8'(($urandom % 255) + 1);
        req = 4'b0001;
        step();
        check_eq("mr_new_ack", ack, 4'b0001);
        req = '0;
        run(FRAME + 10);

        // Randomized traffic against the model
        for (int c = 0; c < 12000; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k] && ($urandom % 40) == 0) begin
                    data[8*k +: 8] = 8'($urandom);
                    req[k]         = 1'b1;
                end else if (req[k] && ($urandom % 300) == 0) begin
                    req[k] = 1'b0;
                end
            end
            if (($urandom % 700) == 0) en = ~en;
            step();
            for (int k = 0; k < NREQ; k++)
                if (ack[k] && ($urandom % 2) == 0) req[k] = 1'b0;
        end
        req = '0;
        en  = 1'b1;
        run(FRAME + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
